// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-stage constants and the fetch-to-decode bus layout.
// The bus is packed {adel, inst, pc}, matching the decode stage's unpacking order.
package if_fetch_queue_pkg;

    localparam int          FS_TO_DS_BUS_WD  = 65;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EX_VECTOR        = 32'hbfc00380;

    typedef struct packed {
        logic        adel;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    function automatic logic pc_aligned(input logic [1:0] pc_low);
        return pc_low == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// Synchronous FIFO with flush; any DEPTH >= 1, not only powers of two.
// Push while full is honoured only when a pop happens in the same cycle.
module fetch_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: credit-based SRAM request issue, PC tag queue,
// instruction buffer toward decode, and redirect with in-flight cancellation.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_inst,
    output logic [31:0] fs_to_ds_pc,
    output logic        fs_to_ds_adel,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = $clog2(IBUF_DEPTH + 1);
    localparam int SW = ((IW > OW) ? IW : OW) + 1;

    logic [31:0]   fetch_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] cancel_cnt;
    logic          halted;

    logic [31:0]   tag_pc;
    logic [OW-1:0] tag_count;
    logic          tag_full;
    logic          tag_empty;

    fs_to_ds_t     ibuf_wdata;
    fs_to_ds_t     ibuf_head;
    logic [IW-1:0] ibuf_count;
    logic          ibuf_full;
    logic          ibuf_empty;

    logic          accept;
    logic          resp_valid;
    logic          resp_push;
    logic          adel_push;
    logic          ibuf_push;
    logic          ibuf_pop;
    logic [SW-1:0] credit_used;
    logic          unused_tag_count;

    // Every accepted request owns a buffer slot, so a response can always be stored.
    assign credit_used = SW'(ibuf_count) + SW'(outstanding);

    assign inst_sram_req = !redirect_valid && !halted && pc_aligned(fetch_pc[1:0])
                        && (outstanding < OW'(MAX_OUTSTANDING)) && !tag_full
                        && (credit_used < SW'(IBUF_DEPTH));
    assign inst_sram_addr = fetch_pc;

    assign accept     = inst_sram_req && inst_sram_addr_ok;
    assign resp_valid = inst_sram_data_ok && !tag_empty;
    assign resp_push  = resp_valid && (cancel_cnt == '0) && !redirect_valid;

    // A misaligned PC is reported once, after every older request has been cancelled out.
    assign adel_push  = !redirect_valid && !halted && !pc_aligned(fetch_pc[1:0])
                     && (outstanding == cancel_cnt) && !ibuf_full;
    assign ibuf_push  = resp_push || adel_push;

    always_comb begin
        ibuf_wdata.adel = adel_push;
        ibuf_wdata.inst = adel_push ? 32'h0 : inst_sram_rdata;
        ibuf_wdata.pc   = adel_push ? fetch_pc : tag_pc;
    end

    assign fs_to_ds_valid = !ibuf_empty && !redirect_valid;
    assign ibuf_pop       = fs_to_ds_valid && ds_allowin;
    assign fs_to_ds_inst  = ibuf_empty ? 32'h0 : ibuf_head.inst;
    assign fs_to_ds_pc    = ibuf_empty ? 32'h0 : ibuf_head.pc;
    assign fs_to_ds_adel  = !ibuf_empty && ibuf_head.adel;

    assign unused_tag_count = ^tag_count;

    fetch_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_queue (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (resp_valid),
        .flush (1'b0),
        .wdata (fetch_pc),
        .rdata (tag_pc),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    fetch_sync_fifo #(
        .WIDTH (FS_TO_DS_BUS_WD),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (ibuf_push),
        .pop   (ibuf_pop),
        .flush (redirect_valid),
        .wdata (ibuf_wdata),
        .rdata (ibuf_head),
        .count (ibuf_count),
        .full  (ibuf_full),
        .empty (ibuf_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            cancel_cnt  <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(resp_valid);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc   <= redirect_pc;
                halted     <= 1'b0;
                cancel_cnt <= outstanding - OW'(resp_valid);
            end else begin
                if (accept)    fetch_pc <= fetch_pc + 32'd4;
                if (adel_push) halted   <= 1'b1;
                if (resp_valid && (cancel_cnt != '0)) cancel_cnt <= cancel_cnt - OW'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed and randomised bench for if_fetch_queue with an SRAM responder model
// and a scoreboard of expected decode-side entries.
module tb_if_fetch_queue;

    localparam int          IBUF_DEPTH = 4;
    localparam int          MAX_OUT    = 2;
    localparam logic [31:0] RESET_PC   = 32'hbfc00000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_inst;
    logic [31:0] fs_to_ds_pc;
    logic        fs_to_ds_adel;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_fetch_queue #(
        .IBUF_DEPTH      (IBUF_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_inst     (fs_to_ds_inst),
        .fs_to_ds_pc       (fs_to_ds_pc),
        .fs_to_ds_adel     (fs_to_ds_adel),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          cancelled;
    } pend_t;

    typedef struct packed {
        logic        adel;
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    pend_t       pend_q[$];
    entry_t      exp_q[$];
    logic [31:0] ref_pc;
    int          compared;
    int          mismatched;
    int          accepts;
    int          delivered;
    int          addr_mode;
    int          dok_mode;
    int          allow_mode;
    bit          force_dok;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, sample #1 later, advance the reference model.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit     dok;
        entry_t got;
        entry_t e;
        pend_t  p;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        case (addr_mode)
            0:       inst_sram_addr_ok = 1'b1;
            1:       inst_sram_addr_ok = 1'($urandom_range(0, 1));
            default: inst_sram_addr_ok = 1'b0;
        endcase
        case (allow_mode)
            0:       ds_allowin = 1'b1;
            1:       ds_allowin = ($urandom_range(0, 3) != 0);
            default: ds_allowin = 1'b0;
        endcase
        dok = (pend_q.size() != 0) &&
              (force_dok || dok_mode == 0 || (dok_mode == 1 && $urandom_range(0, 2) != 0));
        inst_sram_data_ok = dok;
        inst_sram_rdata   = dok ? mem_word(pend_q[0].pc) : 32'h0;
        #1;
        check("outstanding_bound", 65'(pend_q.size() <= MAX_OUT), 65'(1));
        if (redir) begin
            check("valid_in_redirect", 65'(fs_to_ds_valid), 65'(0));
            check("req_in_redirect", 65'(inst_sram_req), 65'(0));
        end
        if (ref_pc[1:0] != 2'b00)
            check("req_while_misaligned", 65'(inst_sram_req), 65'(0));
        if (fs_to_ds_valid && ds_allowin) begin
            got = {fs_to_ds_adel, fs_to_ds_inst, fs_to_ds_pc};
            check("scoreboard_nonempty", 65'(exp_q.size() != 0), 65'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("delivered_entry", got, e);
            end
            delivered++;
        end
        if (redir) begin
            foreach (pend_q[i]) pend_q[i].cancelled = 1'b1;
            exp_q.delete();
            ref_pc = rpc;
            if (rpc[1:0] != 2'b00) exp_q.push_back({1'b1, 32'h0, rpc});
        end
        if (dok) begin
            p = pend_q.pop_front();
            if (!p.cancelled) exp_q.push_back({1'b0, mem_word(p.pc), p.pc});
        end
        if (inst_sram_req && inst_sram_addr_ok) begin
            check("req_addr", 65'(inst_sram_addr), 65'(ref_pc));
            pend_q.push_back('{pc: ref_pc, cancelled: 1'b0});
            ref_pc = ref_pc + 32'd4;
            accepts++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic drain(input int budget);
        int n;
        addr_mode  = 2;
        dok_mode   = 0;
        allow_mode = 0;
        n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        check("drain_done", 65'(pend_q.size() + exp_q.size()), 65'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset             = 1'b1;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        ds_allowin        = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 65'(fs_to_ds_valid), 65'(0));
        check("reset_out_pc", 65'(fs_to_ds_pc), 65'(0));
        check("reset_out_adel", 65'(fs_to_ds_adel), 65'(0));
        reset = 1'b0;
        pend_q.delete();
        exp_q.delete();
        ref_pc = RESET_PC;
        #1;
        check("post_reset_req", 65'(inst_sram_req), 65'(1));
        check("post_reset_addr", 65'(inst_sram_addr), 65'(RESET_PC));
    endtask

    initial begin
        int a0;
        int d0;
        bit redir;
        logic [31:0] rpc;
        compared   = 0;
        mismatched = 0;
        accepts    = 0;
        delivered  = 0;
        force_dok  = 1'b0;
        addr_mode  = 0;
        dok_mode   = 0;
        allow_mode = 0;
        reset      = 1'b0;
        do_reset();

        // Streaming from the reset vector, one word per cycle once warm.
        addr_mode = 0; dok_mode = 0; allow_mode = 0;
        run(6);
        d0 = delivered;
        run(10);
        check("stream_rate", 65'(delivered - d0), 65'(10));

        // Back-pressure: credits cap accepted requests at the buffer depth.
        drain(50);
        addr_mode = 0; dok_mode = 0; allow_mode = 2;
        a0 = accepts;
        run(20);
        check("bp_accepts", 65'(accepts - a0), 65'(IBUF_DEPTH));
        check("bp_req_low", 65'(inst_sram_req), 65'(0));
        check("bp_valid_held", 65'(fs_to_ds_valid), 65'(1));
        drain(50);

        // Redirect with two requests in flight and a non-empty buffer.
        addr_mode = 0; dok_mode = 0; allow_mode = 2;
        run(3);
        dok_mode = 2;
        run(2);
        check("t3_in_flight", 65'(pend_q.size()), 65'(2));
        check("t3_buffer_busy", 65'(fs_to_ds_valid), 65'(1));
        cycle(1'b1, 32'h8000_1000);
        addr_mode = 0; dok_mode = 0; allow_mode = 0;
        d0 = delivered;
        run(12);
        check("t3_delivered_after", 65'(delivered - d0 > 4), 65'(1));
        drain(50);

        // Redirect coinciding with a response while two are outstanding.
        addr_mode = 0; dok_mode = 2; allow_mode = 0;
        run(2);
        check("t4_in_flight", 65'(pend_q.size()), 65'(2));
        force_dok = 1'b1;
        cycle(1'b1, 32'h8000_2000);
        force_dok = 1'b0;
        check("t4_cancel_left", 65'(pend_q.size()), 65'(1));
        addr_mode = 0; dok_mode = 0;
        run(10);

        // Misaligned redirect from a streaming state: one adel entry, then silence.
        cycle(1'b1, 32'h8000_0002);
        a0 = accepts;
        run(10);
        check("t5_no_accepts", 65'(accepts - a0), 65'(0));
        check("t5_adel_drained", 65'(exp_q.size()), 65'(0));
        cycle(1'b1, 32'h8000_3000);
        a0 = accepts;
        run(8);
        check("t5_resumed", 65'(accepts - a0 > 0), 65'(1));
        drain(50);

        // Random handshakes and redirects against the reference model.
        addr_mode = 1; dok_mode = 1; allow_mode = 1;
        for (int i = 0; i < 800; i++) begin
            redir = ($urandom_range(0, 24) == 0);
            rpc   = $urandom;
            rpc[1:0] = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
            cycle(redir, rpc);
        end
        drain(200);

        // Mid-operation reset.
        addr_mode = 0; dok_mode = 0; allow_mode = 0;
        run(5);
        do_reset();
        run(8);
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
